// File: rtl/otter_run_controller.sv
// otter_run_controller
//   Sequences a run of the OTTER core: holds the core in reset for
//   RESET_CYCLES after START, then releases it and plays a small
//   time-scheduled switch stimulus table onto SWITCHES. The run ends on the
//   first of: a write to RESULT_ADDR (pass/fail from the data), the PC staying
//   unchanged for STALL_CYCLES cycles, or CYCLES reaching TIMEOUT.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   START               begin a run (accepted in IDLE or DONE only)
//   CFG_WE/ADDR/SW/DWELL stimulus table write port (IDLE or DONE only)
//   CFG_COUNT           number of valid table entries, latched on START
//   CPU_PC              core program counter, watched for self-loops
//   IO_WR/ADDR/DATA     core MMIO write bus, watched for the result write
//   CPU_RST             reset to the core (low only in RUN)
//   SWITCHES            stimulus to the core switch input
//   BUSY, DONE          run in progress / run finished
//   PASS, FAIL_CODE     outcome: 0 pass, 1 wrong value, 2 PC stall, 3 timeout
//   CYCLES              RUN cycles elapsed, frozen once DONE
module otter_run_controller #(
  parameter int          SW_WIDTH     = 16,
  parameter int          DEPTH        = 8,
  parameter int          DWELL_W      = 16,
  parameter int          RESET_CYCLES = 30,
  parameter int          STALL_CYCLES = 8,
  parameter int          TIMEOUT      = 1000000,
  parameter logic [31:0] RESULT_ADDR  = 32'h1100_00F0,
  parameter logic [31:0] PASS_VALUE   = 32'h0000_600D
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       CFG_WE,
  input  logic [$clog2(DEPTH)-1:0]   CFG_ADDR,
  input  logic [SW_WIDTH-1:0]        CFG_SW,
  input  logic [DWELL_W-1:0]         CFG_DWELL,
  input  logic [$clog2(DEPTH):0]     CFG_COUNT,
  input  logic [31:0]                CPU_PC,
  input  logic                       IO_WR,
  input  logic [31:0]                IO_ADDR,
  input  logic [31:0]                IO_DATA,
  output logic                       CPU_RST,
  output logic [SW_WIDTH-1:0]        SWITCHES,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       PASS,
  output logic [1:0]                 FAIL_CODE,
  output logic [31:0]                CYCLES
);

  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = SW_WIDTH + DWELL_W;
  localparam int HW  = $clog2(RESET_CYCLES + 1);
  localparam int SCW = $clog2(STALL_CYCLES + 1);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(RESET_CYCLES - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYCLES - 1);
  localparam logic [AW-1:0]  LAST_IDX   = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [AW:0]         count_q, count_d;
  logic [AW-1:0]       index_q, index_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [SW_WIDTH-1:0] sw_q, sw_d;
  logic [31:0]         pc_q, pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic [SCW-1:0]      stall_q, stall_d;
  logic [31:0]         cycles_q, cycles_d;
  logic                pass_q, pass_d;
  logic [1:0]          fail_q, fail_d;

  // Stimulus table: {switch value, dwell} per entry, registered read.
  logic [EW-1:0]       stim_mem [DEPTH];
  logic [EW-1:0]       rd_q;
  logic [AW-1:0]       rd_addr;
  logic                cfg_we_ok;

  logic [31:0]         cycles_inc;
  logic                pc_same;
  logic                stall_hit;
  logic                result_hit;
  logic                timeout_hit;
  logic                hold_entry;

  assign cfg_we_ok = CFG_WE && !RST && (state_q == S_IDLE || state_q == S_DONE);

  // rd_q always carries the entry that would be loaded at the next load
  // point: entry 0 before RUN, entry index+1 during RUN. A write landing on
  // the address being read is forwarded so a START on the same edge as the
  // last table write still sees the new entry.
  always_ff @(posedge CLK) begin
    if (cfg_we_ok) begin
      stim_mem[CFG_ADDR] <= {CFG_SW, CFG_DWELL};
    end
    if (cfg_we_ok && CFG_ADDR == rd_addr) begin
      rd_q <= {CFG_SW, CFG_DWELL};
    end else begin
      rd_q <= stim_mem[rd_addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      count_q    <= '0;
      index_q    <= '0;
      dwell_q    <= '0;
      sw_q       <= '0;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
      stall_q    <= '0;
      cycles_q   <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      index_q    <= index_d;
      dwell_q    <= dwell_d;
      sw_q       <= sw_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      stall_q    <= stall_d;
      cycles_q   <= cycles_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    count_d     = count_q;
    index_d     = index_q;
    dwell_d     = dwell_q;
    sw_d        = sw_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    stall_d     = stall_q;
    cycles_d    = cycles_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    pc_same     = 1'b0;
    stall_hit   = 1'b0;
    result_hit  = 1'b0;
    timeout_hit = 1'b0;
    hold_entry  = 1'b0;
    cycles_inc  = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d  = S_HOLD;
          hold_d   = HOLD_LOAD;
          count_d  = CFG_COUNT;
          sw_d     = '0;
          cycles_d = '0;
          pass_d   = 1'b0;
          fail_d   = 2'd0;
        end
      end

      S_HOLD: begin
        if (hold_q == '0) begin
          state_d    = S_RUN;
          index_d    = '0;
          dwell_d    = rd_q[DWELL_W-1:0];
          sw_d       = (count_q == '0) ? '0 : rd_q[EW-1:DWELL_W];
          pc_valid_d = 1'b0;
          stall_d    = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      S_RUN: begin
        cycles_d   = cycles_inc;
        pc_d       = CPU_PC;
        pc_valid_d = 1'b1;
        // The first RUN cycle has no previous PC to compare against.
        pc_same    = pc_valid_q && (CPU_PC == pc_q);
        stall_d    = pc_same ? stall_q + 1'b1 : '0;
        stall_hit  = pc_same && (stall_q == STALL_LAST);
        result_hit = IO_WR && (IO_ADDR == RESULT_ADDR);
        timeout_hit = (cycles_inc == 32'(TIMEOUT));

        if (result_hit) begin
          state_d = S_DONE;
          pass_d  = (IO_DATA == PASS_VALUE);
          fail_d  = (IO_DATA == PASS_VALUE) ? 2'd0 : 2'd1;
        end else if (stall_hit) begin
          state_d = S_DONE;
          pass_d  = 1'b0;
          fail_d  = 2'd2;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          pass_d  = 1'b0;
          fail_d  = 2'd3;
        end else begin
          // A dwell of 0 never counts down, so dwell_q==0 marks a
          // hold-forever entry; countdown advances when it reaches 1.
          hold_entry = (dwell_q == '0) || (count_q == '0) ||
                       ({1'b0, index_q} == count_q - 1'b1) ||
                       (index_q == LAST_IDX);
          if (!hold_entry) begin
            if (dwell_q == DWELL_W'(1)) begin
              index_d = index_q + 1'b1;
              dwell_d = rd_q[DWELL_W-1:0];
              sw_d    = rd_q[EW-1:DWELL_W];
            end else begin
              dwell_d = dwell_q - 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    rd_addr = (state_d == S_RUN) ? index_d + 1'b1 : '0;
  end

  assign CPU_RST   = (state_q != S_RUN);
  assign BUSY      = (state_q == S_HOLD) || (state_q == S_RUN);
  assign DONE      = (state_q == S_DONE);
  assign SWITCHES  = sw_q;
  assign PASS      = pass_q;
  assign FAIL_CODE = fail_q;
  assign CYCLES    = cycles_q;

endmodule

// File: tb/tb_otter_run_controller.sv
// Directed bench for otter_run_controller. Expected switch values per RUN
// cycle and expected end-of-run status are queued when a run is set up and
// compared as the DUT produces them.
module tb_otter_run_controller;

  localparam logic [31:0] RES_ADDR = 32'h1100_00F0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        CFG_WE;
  logic [2:0]  CFG_ADDR;
  logic [15:0] CFG_SW;
  logic [15:0] CFG_DWELL;
  logic [3:0]  CFG_COUNT;
  logic [31:0] CPU_PC;
  logic        IO_WR;
  logic [31:0] IO_ADDR;
  logic [31:0] IO_DATA;
  logic        CPU_RST;
  logic [15:0] SWITCHES;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [1:0]  FAIL_CODE;
  logic [31:0] CYCLES;

  otter_run_controller #(
    .SW_WIDTH(16), .DEPTH(8), .DWELL_W(16), .RESET_CYCLES(4),
    .STALL_CYCLES(8), .TIMEOUT(100),
    .RESULT_ADDR(32'h1100_00F0), .PASS_VALUE(32'h0000_600D)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .CFG_WE(CFG_WE),
    .CFG_ADDR(CFG_ADDR), .CFG_SW(CFG_SW), .CFG_DWELL(CFG_DWELL),
    .CFG_COUNT(CFG_COUNT), .CPU_PC(CPU_PC), .IO_WR(IO_WR),
    .IO_ADDR(IO_ADDR), .IO_DATA(IO_DATA), .CPU_RST(CPU_RST),
    .SWITCHES(SWITCHES), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .FAIL_CODE(FAIL_CODE), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;   // 0 PASS, 1 FAIL_CODE, 2 CYCLES, 3 SWITCHES
    logic [31:0] val;
  } exp_t;

  exp_t        res_q[$];
  logic [15:0] sw_exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  // Bench copy of the stimulus table contents.
  logic [15:0] m_sw    [3] = '{16'h0001, 16'h00F0, 16'hFFFF};
  logic [15:0] m_dwell [3] = '{16'd5, 16'd3, 16'd0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] pc_of(input int mode, input int k);
    if (mode == 0 || k < 10) return 32'(4 * k);
    if (mode == 2 && k == 14) return 32'h44;
    return 32'h40;
  endfunction

  // Expected SWITCHES for RUN cycles 0..ncyc-1 from the schedule semantics.
  task automatic push_sw(input int count, input int ncyc);
    int idx = 0;
    int cnt = int'(m_dwell[0]);
    for (int k = 0; k < ncyc; k++) begin
      sw_exp_q.push_back((count == 0) ? 16'h0000 : m_sw[idx]);
      if (count != 0 && cnt != 0 && idx != count - 1) begin
        if (cnt == 1) begin
          idx++;
          cnt = int'(m_dwell[idx]);
        end else begin
          cnt--;
        end
      end
    end
  endtask

  task automatic push_res(input logic p, input logic [1:0] f, input int cyc, input logic [15:0] sw);
    res_q.push_back('{0, {31'd0, p}});
    res_q.push_back('{1, {30'd0, f}});
    res_q.push_back('{2, 32'(cyc)});
    res_q.push_back('{3, {16'd0, sw}});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"}, {31'd0, CPU_RST}, 32'd1);
    check({tag, "_switches"}, {16'd0, SWITCHES}, 32'd0);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_done"}, {31'd0, DONE}, 32'd0);
    check({tag, "_pass"}, {31'd0, PASS}, 32'd0);
    check({tag, "_code"}, {30'd0, FAIL_CODE}, 32'd0);
    check({tag, "_cycles"}, CYCLES, 32'd0);
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [15:0] sw, input logic [15:0] dw);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_SW = sw; CFG_DWELL = dw;
    tick();
    CFG_WE = 1'b0;
  endtask

  // START pulse, then the 4 hold cycles; a result write is driven throughout
  // the hold and must be ignored. Ends in RUN cycle 0.
  task automatic start_run(input logic [3:0] count);
    CFG_COUNT = count; START = 1'b1;
    tick();
    START = 1'b0;
    IO_WR = 1'b1; IO_ADDR = RES_ADDR; IO_DATA = 32'h600D;
    check("hold_pass_clr", {31'd0, PASS}, 32'd0);
    check("hold_code_clr", {30'd0, FAIL_CODE}, 32'd0);
    check("hold_cycles_clr", CYCLES, 32'd0);
    for (int h = 0; h < 4; h++) begin
      check("hold_cpu_rst", {31'd0, CPU_RST}, 32'd1);
      check("hold_busy", {31'd0, BUSY}, 32'd1);
      check("hold_switches", {16'd0, SWITCHES}, 32'd0);
      check("hold_done", {31'd0, DONE}, 32'd0);
      tick();
    end
    IO_WR = 1'b0;
    check("run0_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    check("run0_busy", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic run(input int mode, input int wr_cycle, input logic [31:0] wr_data, input int inj_cycle);
    bit   done_seen = 1'b0;
    exp_t e;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      CPU_PC = pc_of(mode, k);
      IO_WR = (k == wr_cycle); IO_ADDR = RES_ADDR; IO_DATA = wr_data;
      START = (k == inj_cycle); CFG_WE = (k == inj_cycle);
      CFG_ADDR = 3'd0; CFG_SW = 16'h1234; CFG_DWELL = 16'd1;
      if (sw_exp_q.size() > 0) check("run_switches", {16'd0, SWITCHES}, {16'd0, sw_exp_q.pop_front()});
      tick();
      if (DONE) done_seen = 1'b1;
    end
    IO_WR = 1'b0; START = 1'b0; CFG_WE = 1'b0;
    check("done_reached", {31'd0, done_seen}, 32'd1);
    check("sw_exp_left", sw_exp_q.size(), 32'd0);
    sw_exp_q.delete();
    check("done_busy", {31'd0, BUSY}, 32'd0);
    check("done_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    while (res_q.size() > 0) begin
      e = res_q.pop_front();
      case (e.kind)
        0: check("done_pass", {31'd0, PASS}, e.val);
        1: check("done_code", {30'd0, FAIL_CODE}, e.val);
        2: check("done_cycles", CYCLES, e.val);
        default: check("done_switches", {16'd0, SWITCHES}, e.val);
      endcase
    end
    $display("[TB] run end: pass=%0d code=%0d cycles=%0d switches=%h", PASS, FAIL_CODE, CYCLES, SWITCHES);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_SW = '0;
    CFG_DWELL = '0; CFG_COUNT = '0; CPU_PC = '0; IO_WR = 1'b0;
    IO_ADDR = '0; IO_DATA = '0;
    tick(); tick();
    check_reset_outputs("reset");
    RST = 1'b0;
    tick();
    check_reset_outputs("idle");

    for (int i = 0; i < 3; i++) write_entry(3'(i), m_sw[i], m_dwell[i]);

    // Three-entry schedule, passing result on RUN cycle 20.
    start_run(4'd3);
    push_sw(3, 21);
    push_res(1'b1, 2'd0, 21, 16'hFFFF);
    run(0, 20, 32'h600D, -1);

    // From DONE: two entries, wrong result value.
    start_run(4'd2);
    push_sw(2, 21);
    push_res(1'b0, 2'd1, 21, 16'h00F0);
    run(0, 20, 32'h0BAD, -1);

    // PC stall, with START and a table write attempted mid-run.
    start_run(4'd3);
    push_sw(3, 19);
    push_res(1'b0, 2'd2, 19, 16'hFFFF);
    run(1, -1, 32'h0, 3);

    // Stall with a glitch at cycle 14; table must read back unchanged.
    start_run(4'd3);
    push_sw(3, 24);
    push_res(1'b0, 2'd2, 24, 16'hFFFF);
    run(2, -1, 32'h0, -1);

    // Empty schedule, watchdog timeout.
    start_run(4'd0);
    push_sw(0, 100);
    push_res(1'b0, 2'd3, 100, 16'h0000);
    run(0, -1, 32'h0, -1);

    // Result write on the timeout cycle takes priority.
    start_run(4'd0);
    push_res(1'b1, 2'd0, 100, 16'h0000);
    run(0, 99, 32'h600D, -1);

    // Reset asserted in the middle of RUN.
    start_run(4'd3);
    for (int k = 0; k < 7; k++) begin
      CPU_PC = pc_of(0, k);
      tick();
    end
    check("mid_run_switches", {16'd0, SWITCHES}, 32'h00F0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset_outputs("mid_run_rst");
    $display("[TB] mid-run reset applied");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
